// File: rtl/bcd_updown_counter.sv
// Multi-digit modulo-MOD up/down counter with clear, clamped parallel load,
// optional saturation, a registered full-count wrap pulse and a sticky overflow flag.
module bcd_updown_counter #(
  parameter int NDIGITS  = 4,
  parameter int MOD      = 10,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 load,
  input  logic                 up,
  input  logic [4*NDIGITS-1:0] load_val,
  output logic [4*NDIGITS-1:0] count,
  output logic                 wrap,
  output logic                 at_max,
  output logic                 at_min,
  output logic                 ovf
);

  localparam int         W    = 4 * NDIGITS;
  localparam logic [3:0] DMAX = 4'(MOD - 1);
  localparam logic [4:0] DLIM = 5'(MOD);

  logic [NDIGITS-1:0] dig_max;
  logic [NDIGITS-1:0] dig_min;
  logic [W-1:0]       count_inc;
  logic [W-1:0]       count_dec;
  logic [W-1:0]       load_clamped;
  logic               full;

  always_comb begin
    for (int i = 0; i < NDIGITS; i++) begin
      dig_max[i] = (count[4*i +: 4] == DMAX);
      dig_min[i] = (count[4*i +: 4] == 4'd0);
    end
  end

  assign at_max = &dig_max;
  assign at_min = &dig_min;
  assign full   = up ? at_max : at_min;

  // Ripple carry/borrow resolved combinationally so every digit settles in one edge.
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] d;
    logic [3:0] ld;
    count_inc    = count;
    count_dec    = count;
    load_clamped = '0;
    carry        = 1'b1;
    borrow       = 1'b1;
    d            = 4'd0;
    ld           = 4'd0;
    for (int i = 0; i < NDIGITS; i++) begin
      d = count[4*i +: 4];
      if (carry)
        count_inc[4*i +: 4] = dig_max[i] ? 4'd0 : d + 4'd1;
      if (borrow)
        count_dec[4*i +: 4] = dig_min[i] ? DMAX : d - 4'd1;
      carry  = carry & dig_max[i];
      borrow = borrow & dig_min[i];
      ld = load_val[4*i +: 4];
      load_clamped[4*i +: 4] = ({1'b0, ld} >= DLIM) ? DMAX : ld;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      wrap  <= 1'b0;
    end else if (en) begin
      if (full && SATURATE) begin
        wrap <= 1'b0;
        ovf  <= 1'b1;
      end else begin
        count <= up ? count_inc : count_dec;
        wrap  <= full;
        if (full)
          ovf <= 1'b1;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
